// File: rtl/pipeline_elastic.sv
// Elastic valid/ready pipeline register chain with bubble collapse, global stall and flush.
// Optional occupancy counter and occ port are built when PIPE_OCC_EN is defined.
module pipeline_elastic #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [DATA_W-1:0] dataQ [DEPTH];
  logic [DEPTH-1:0]  validQ;
  logic [DEPTH:0]    rdy;

  // A stage can load when the output drains or any stage from it onward holds a bubble.
  assign rdy[DEPTH] = out_ready;
  for (genvar g = 0; g < DEPTH; g++) begin : gRdy
    assign rdy[g] = out_ready | ~(&validQ[DEPTH-1:g]);
  end

  assign in_ready  = rdy[0] & enable & ~flush;
  assign out_valid = validQ[DEPTH-1] & enable & ~flush;
  assign out_data  = dataQ[DEPTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validQ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dataQ[i] <= '0;
      end
    end else if (flush) begin
      validQ <= '0;
    end else if (enable) begin
      if (rdy[0]) begin
        dataQ[0]  <= in_data;
        validQ[0] <= in_valid;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          dataQ[i]  <= dataQ[i-1];
          validQ[i] <= validQ[i-1];
        end
      end
    end
  end

`ifdef PIPE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH+1);

  logic             accept;
  logic             retire;
  logic [OCC_W-1:0] occQ;

  assign accept = in_valid & in_ready;
  assign retire = out_valid & out_ready;
  assign occ    = occQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occQ <= '0;
    end else if (flush) begin
      occQ <= '0;
    end else begin
      occQ <= occQ + OCC_W'(accept) - OCC_W'(retire);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_elastic.sv
// Randomised and directed bench for pipeline_elastic (DEPTH=5 main instance, DEPTH=1 corner instance),
// checked against a queue-based item/position model.
module tb_pipeline_elastic;

  localparam int DW = 9;
  localparam int D  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable, flush, inValid, outReady;
  logic [DW-1:0] inData;
  logic          inReady, outValid;
  logic [DW-1:0] outData;

  logic          en1, fl1, in1Valid, out1Ready;
  logic [DW-1:0] in1Data;
  logic          in1Ready, out1Valid;
  logic [DW-1:0] out1Data;

`ifdef PIPE_OCC_EN
  logic [2:0] occ;
  logic       occ1;
`endif

  int errCount   = 0;
  int checkCount = 0;

  // Main model: oldest item first, each with its current stage index.
  int            qPos[$];
  logic [DW-1:0] qData[$];
  logic          obsOutValid;

  logic          have1;
  logic [DW-1:0] data1;
  int            accepted1, delivered1;

  always #5 clk = ~clk;

  pipeline_elastic #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .in_data(inData), .in_valid(inValid), .in_ready(inReady),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady)
`ifdef PIPE_OCC_EN
    , .occ(occ)
`endif
  );

  pipeline_elastic #(.DATA_W(DW), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .flush(fl1),
    .in_data(in1Data), .in_valid(in1Valid), .in_ready(in1Ready),
    .out_data(out1Data), .out_valid(out1Valid), .out_ready(out1Ready)
`ifdef PIPE_OCC_EN
    , .occ(occ1)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle on the main instance, checks both instances, then advances both models.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic ordy,
                               input logic en, input logic fl);
    logic expIn, expOv, expIn1;
    int   n;
    @(negedge clk);
    inValid  = v;
    inData   = d;
    outReady = ordy;
    enable   = en;
    flush    = fl;
    #1;
    expIn = en && !fl && (qPos.size() < D || ordy);
    expOv = en && !fl && qPos.size() > 0 && qPos[0] == D-1;
    obsOutValid = outValid;
    checkOutput("in_ready", 32'(inReady), 32'(expIn));
    checkOutput("out_valid", 32'(outValid), 32'(expOv));
    if (expOv) checkOutput("out_data", 32'(outData), 32'(qData[0]));
`ifdef PIPE_OCC_EN
    checkOutput("occ", 32'(occ), 32'(qPos.size()));
`endif
    expIn1 = !have1 || out1Ready;
    checkOutput("d1_in_ready", 32'(in1Ready), 32'(expIn1));
    checkOutput("d1_out_valid", 32'(out1Valid), 32'(have1));
    if (have1) checkOutput("d1_out_data", 32'(out1Data), 32'(data1));

    if (fl) begin
      qPos.delete();
      qData.delete();
    end else if (en) begin
      n = qPos.size();
      for (int k = 0; k < n; k++) begin
        if (ordy || k < D-1-qPos[k]) qPos[k]++;
      end
      if (n > 0 && qPos[0] == D) begin
        void'(qPos.pop_front());
        void'(qData.pop_front());
      end
      if (v && expIn) begin
        qPos.push_back(0);
        qData.push_back(d);
      end
    end

    if (have1 && out1Ready) begin
      delivered1++;
      have1 = 1'b0;
    end
    if (in1Valid && expIn1) begin
      accepted1++;
      have1 = 1'b1;
      data1 = in1Data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic asyncReset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_out_data", 32'(outData), 32'd0);
    checkOutput("rst_d1_out_valid", 32'(out1Valid), 32'd0);
`ifdef PIPE_OCC_EN
    checkOutput("rst_occ", 32'(occ), 32'd0);
`endif
    qPos.delete();
    qData.delete();
    have1 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    int firstOut;
    rst = 1'b0; enable = 1'b1; flush = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b1;
    en1 = 1'b1; fl1 = 1'b0; in1Valid = 1'b0; in1Data = '0; out1Ready = 1'b1;
    have1 = 1'b0; data1 = '0; accepted1 = 0; delivered1 = 0; obsOutValid = 1'b0;
    #12;
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_out_data", 32'(outData), 32'd0);
    checkOutput("reset_in_ready", 32'(inReady), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;

    // Stream 0x001..0x00A and measure acceptance-to-output latency.
    firstOut = -1;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(i <= 10, DW'(i), 1'b1, 1'b1, 1'b0);
      if (obsOutValid && firstOut < 0) firstOut = i;
    end
    checkOutput("latency_call", 32'(firstOut), 32'd6);

    // Back-pressure with a bubble, fill until in_ready drops, then drain.
    applyStimulus(1'b1, 9'h011, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
    for (int i = 2; i <= 7; i++) applyStimulus(1'b1, DW'(i * 'h11), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 9'h000, 1'b1, 1'b1, 1'b0);

    // Stall for three cycles mid-stream.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, DW'(9'h080 + i), 1'b1, !(i >= 4 && i < 7), 1'b0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 9'h000, 1'b1, 1'b1, 1'b0);

    // Flush with four items in flight while offering 0x1FF.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(9'h0A0 + i), 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 9'h1FF, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 9'h1FF, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset with three items in flight, then restart.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(9'h0C0 + i), 1'b1, 1'b1, 1'b0);
    asyncReset();
    for (int i = 0; i < 9; i++) applyStimulus(i < 3, DW'(9'h0D0 + i), 1'b1, 1'b1, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0);
    end

    // DEPTH=1 corner: back-to-back offers with out_ready toggling each cycle.
    for (int i = 0; i < 30; i++) begin
      in1Valid  = 1'b1;
      in1Data   = DW'(9'h100 + i);
      out1Ready = i[0];
      applyStimulus(1'b0, 9'h000, 1'b1, 1'b1, 1'b0);
    end
    in1Valid  = 1'b0;
    out1Ready = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 9'h000, 1'b1, 1'b1, 1'b0);
    checkOutput("d1_delivered", 32'(delivered1), 32'(accepted1));
    checkOutput("d1_accepted", 32'(accepted1 > 10), 32'd1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipeline_elastic.md
# pipeline_elastic

Parametrised elastic pipeline register chain: DEPTH stages of DATA_W bits, each with its own valid bit, valid/ready handshakes at both ends, a global stall (enable) and a synchronous flush. It is the drop-in pipeline skeleton for processor-style datapaths (fetch → … → writeback). Unlike a plain shift register, it collapses bubbles, tolerates downstream back-pressure without losing data, and can discard in-flight contents on a flush.

## Interface
- DATA_W, 9, payload width in bits (≥1)
- DEPTH, 5, number of pipeline stages (≥1); stage 0 is the entry stage, stage DEPTH-1 drives the output
- clk  input  1  single clock, all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- enable  input  1  global advance enable; 0 freezes every register
- flush  input  1  synchronous flush; clears all stage valid bits
- in_data  input  DATA_W  payload offered upstream
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  block accepts in_data this cycle
- out_data  output  DATA_W  payload of stage DEPTH-1
- out_valid  output  1  out_data is valid and offered downstream
- out_ready  input  1  downstream accepts out_data
- occ  output  $clog2(DEPTH+1)  number of valid stages (present only with PIPE_OCC_EN)

## Operation
- State: data[0..DEPTH-1] (DATA_W each) and valid[0..DEPTH-1].
- rst low (asynchronous): all data = 0, all valid = 0, occ = 0. Consequently in_ready = 1 once enable=1 and flush=0, out_valid = 0, and out_data = 0.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !valid[i] | rdy[i+1].
- Handshake rules:
  - in_ready = rdy[0] & enable & !flush.
  - out_valid = valid[DEPTH-1] & enable & !flush.
  - A transfer occurs only when valid and ready are both 1 in the same cycle.
- Advance, when enable=1 and flush=0: for each stage i with rdy[i]=1:
  - i>0: data[i] ← data[i-1] and valid[i] ← valid[i-1].
  - i=0: data[0] ← in_data and valid[0] ← in_valid.
  - Stages with rdy[i]=0 hold both data and valid.
  - Data registers may load garbage when the incoming valid is 0; only valid-qualified contents are architecturally visible.
- Bubble collapse: an empty stage always accepts from behind it, even while the output is stalled.
- enable=0: all registers hold; in_ready = 0; out_valid = 0; no transfers occur.
- flush=1 (takes priority over enable and all handshakes):
  - Next edge: all valid = 0 and occ = 0. Data registers are unchanged.
  - in_data is not accepted and out_data is not delivered that cycle.
- Reset asserted mid-operation: all in-flight items are discarded immediately. No partial output.
- Ordering: items exit in exactly the order they were accepted. None are lost or duplicated.

## Timing
- Latency: an item accepted at edge N into an empty pipeline with out_ready=1 and enable=1 shows out_valid=1 in the cycle after edge N+DEPTH-1, i.e. DEPTH cycles from acceptance to out_valid.
- Throughput: 1 item/cycle while out_ready=1 and enable=1.
- Full condition: all DEPTH valid bits set and out_ready=0 → in_ready=0 in the same cycle.
- Full with out_ready=1: the chain advances as a whole, in_ready=1, and simultaneous accept and retire occur.
- in_ready depends combinationally on out_ready through the rdy chain. This is the accepted critical path, and no skid buffer is used.
- Simultaneous flush and reset: reset wins (asynchronous).

## Configuration
- PIPE_OCC_EN defined:
  - occ port and an occupancy register are present.
  - occ updates as occ + accept − retire, where accept = in_valid&in_ready and retire = out_valid&out_ready.
  - It resets to 0, clears on flush, and always equals the popcount of valid.
- PIPE_OCC_EN undefined: no occ port and no counter logic. All other behaviour is identical.

## Test plan
- Stream (DATA_W=9, DEPTH=5): reset, enable=1, out_ready=1, in_valid=1 with values 0x001..0x00A on consecutive cycles → first out_valid with 0x001 exactly 5 cycles after acceptance, then 0x002..0x00A on consecutive cycles, in_ready constantly 1.
- Back-pressure and bubble collapse: insert 0x011, an idle cycle, then 0x022 with out_ready=0 → both items packed into stages 4 and 3. Fill until in_ready=0 after 5 items. Release out_ready → items emerge in order with no loss. occ reads 5 then counts down (with PIPE_OCC_EN).
- Stall: enable=0 for 3 cycles mid-stream → in_ready=0, out_valid=0, contents frozen. Resume → sequence continues unchanged.
- Flush: 4 items in flight, pulse flush with in_valid=1 and in_data=0x1FF → in_ready=0 that cycle, next cycle all valid=0 and occ=0, 0x1FF never appears at the output.
- Asynchronous reset mid-stream: drop rst between edges with 3 items in flight → out_valid=0 and out_data=0 immediately. After release, new items flow with DEPTH-cycle latency.
- DEPTH=1 corner: back-to-back items with out_ready toggling every cycle → in_ready tracks !valid | out_ready and each item is delivered exactly once.
